// File: rtl/eth_rx_pkg.sv
// Shared types and width constants for the Ethernet RX dispatcher.
//   rx_state_e : dispatcher FSM states
//   beat_t     : one Avalon-ST beat (data, sop, eop, empty, error)
package eth_rx_pkg;

  localparam int unsigned MAX_DATA_W = 256;  // beat_t data field; DATA_W must not exceed this
  localparam int unsigned EMPTY_W    = 5;
  localparam int unsigned ERR_W      = 6;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StDrop
  } rx_state_e;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [EMPTY_W-1:0]    empty;
    logic [ERR_W-1:0]      error;
  } beat_t;

endpackage

// File: rtl/eth_rx_out_reg.sv
// Single-entry output register for one NIC stream.
//   clk_i, rst_ni : clock, async active-low reset
//   wr_i, beat_i  : write strobe and beat to capture (only honoured when can_load_o)
//   ready_i       : downstream NIC ready
//   can_load_o    : register is empty or is being drained this cycle
//   valid_o,beat_o: registered stream output
import eth_rx_pkg::*;

module eth_rx_out_reg (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  wr_i,
  input  beat_t beat_i,
  input  logic  ready_i,
  output logic  can_load_o,
  output logic  valid_o,
  output beat_t beat_o
);

  logic  valid_q;
  beat_t beat_q;

  assign can_load_o = !valid_q || ready_i;
  assign valid_o    = valid_q;
  assign beat_o     = beat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (can_load_o) begin
      valid_q <= wr_i;
      if (wr_i) beat_q <= beat_i;
    end
  end

endmodule

// File: rtl/eth_rx_dispatcher.sv
// Steers whole frames from one MAC RX Avalon-ST stream to NUM_NICS NIC streams.
//   clk, reset_n           : MAC RX clock, async active-low reset
//   rx_*_in / rx_ready_out : input stream (ready latency 0)
//   nic_*_out / nic_ready_in : per-NIC registered output streams
//   steer_mode_in          : 0 = round-robin, 1 = static steer_idx_in
//   frame_cnt_out, drop_cnt_out, proto_err_cnt_out : wrapping statistics
import eth_rx_pkg::*;

module eth_rx_dispatcher #(
  parameter  int unsigned NUM_NICS = 3,
  parameter  int unsigned DATA_W   = 256,
  parameter  int unsigned CNT_W    = 32,
  localparam int unsigned IdxW     = (NUM_NICS > 1) ? $clog2(NUM_NICS) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [DATA_W-1:0]                  rx_data_in,
  input  logic                               rx_valid_in,
  input  logic                               rx_sop_in,
  input  logic                               rx_eop_in,
  input  logic [EMPTY_W-1:0]                 rx_empty_in,
  input  logic [ERR_W-1:0]                   rx_error_in,
  output logic                               rx_ready_out,
  output logic [NUM_NICS-1:0][DATA_W-1:0]    nic_data_out,
  output logic [NUM_NICS-1:0]                nic_valid_out,
  output logic [NUM_NICS-1:0]                nic_sop_out,
  output logic [NUM_NICS-1:0]                nic_eop_out,
  output logic [NUM_NICS-1:0][EMPTY_W-1:0]   nic_empty_out,
  output logic [NUM_NICS-1:0][ERR_W-1:0]     nic_error_out,
  input  logic [NUM_NICS-1:0]                nic_ready_in,
  input  logic                               steer_mode_in,
  input  logic [IdxW-1:0]                    steer_idx_in,
  output logic [NUM_NICS-1:0][CNT_W-1:0]     frame_cnt_out,
  output logic [CNT_W-1:0]                   drop_cnt_out,
  output logic [CNT_W-1:0]                   proto_err_cnt_out
);

  rx_state_e                        state_q;
  logic [IdxW-1:0]                  tgt_q, rr_q, rr_next, sop_tgt;
  logic                             active_q;  // holds ready low through the first cycle out of reset
  logic [NUM_NICS-1:0][CNT_W-1:0]   frame_cnt_q;
  logic [CNT_W-1:0]                 drop_cnt_q, proto_cnt_q;
  logic                             sop_tgt_ok, idle_drop, xfer;
  logic [NUM_NICS-1:0]              can_load, wr;
  beat_t                            fwd_beat;
  beat_t [NUM_NICS-1:0]             out_beat;

  assign sop_tgt    = steer_mode_in ? steer_idx_in : rr_q;
  assign sop_tgt_ok = (32'(sop_tgt) < NUM_NICS);
  assign idle_drop  = !rx_sop_in || !sop_tgt_ok;
  assign rr_next    = (32'(rr_q) == NUM_NICS - 1) ? '0 : rr_q + 1'b1;
  assign xfer       = rx_valid_in && rx_ready_out;

  always_comb begin
    rx_ready_out = 1'b0;
    unique case (state_q)
      StIdle:  rx_ready_out = idle_drop || can_load[sop_tgt];
      StFwd:   rx_ready_out = can_load[tgt_q];
      StDrop:  rx_ready_out = 1'b1;
      default: rx_ready_out = 1'b0;
    endcase
    rx_ready_out = rx_ready_out && active_q;
  end

  always_comb begin
    fwd_beat                    = '0;
    fwd_beat.data[DATA_W-1:0]   = rx_data_in;
    // A stray SOP inside a frame is passed on as a continuation beat.
    fwd_beat.sop                = rx_sop_in && (state_q == StIdle);
    fwd_beat.eop                = rx_eop_in;
    fwd_beat.empty              = rx_empty_in;
    fwd_beat.error              = rx_error_in;
    wr                          = '0;
    if (xfer) begin
      if (state_q == StIdle && !idle_drop) wr[sop_tgt] = 1'b1;
      else if (state_q == StFwd)           wr[tgt_q]   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      tgt_q       <= '0;
      rr_q        <= '0;
      active_q    <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      proto_cnt_q <= '0;
    end else begin
      active_q <= 1'b1;
      if (xfer) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_sop_in) begin
              proto_cnt_q <= proto_cnt_q + CNT_W'(1);
              if (!rx_eop_in) state_q <= StDrop;
            end else if (!sop_tgt_ok) begin
              drop_cnt_q <= drop_cnt_q + CNT_W'(1);
              if (!rx_eop_in) state_q <= StDrop;
            end else begin
              tgt_q <= sop_tgt;
              rr_q  <= rr_next;
              if (rx_eop_in) frame_cnt_q[sop_tgt] <= frame_cnt_q[sop_tgt] + CNT_W'(1);
              else           state_q <= StFwd;
            end
          end
          StFwd: begin
            if (rx_sop_in) proto_cnt_q <= proto_cnt_q + CNT_W'(1);
            if (rx_eop_in) begin
              frame_cnt_q[tgt_q] <= frame_cnt_q[tgt_q] + CNT_W'(1);
              state_q            <= StIdle;
            end
          end
          StDrop: if (rx_eop_in) state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign frame_cnt_out     = frame_cnt_q;
  assign drop_cnt_out      = drop_cnt_q;
  assign proto_err_cnt_out = proto_cnt_q;

  for (genvar i = 0; i < NUM_NICS; i++) begin : g_nic
    eth_rx_out_reg u_out_reg (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .wr_i       (wr[i]),
      .beat_i     (fwd_beat),
      .ready_i    (nic_ready_in[i]),
      .can_load_o (can_load[i]),
      .valid_o    (nic_valid_out[i]),
      .beat_o     (out_beat[i])
    );
    assign nic_data_out[i]  = out_beat[i].data[DATA_W-1:0];
    assign nic_sop_out[i]   = out_beat[i].sop;
    assign nic_eop_out[i]   = out_beat[i].eop;
    assign nic_empty_out[i] = out_beat[i].empty;
    assign nic_error_out[i] = out_beat[i].error;
  end

endmodule

// File: tb/tb_eth_rx_dispatcher.sv
module tb_eth_rx_dispatcher;

  localparam int N  = 3;
  localparam int DW = 256;
  localparam int CW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [4:0]    empty;
    logic [5:0]    error;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [DW-1:0]         rx_data;
  logic                  rx_valid, rx_sop, rx_eop, rx_ready;
  logic [4:0]            rx_empty;
  logic [5:0]            rx_error;
  logic [N-1:0][DW-1:0]  nic_data;
  logic [N-1:0]          nic_valid, nic_sop, nic_eop, nic_ready;
  logic [N-1:0][4:0]     nic_empty;
  logic [N-1:0][5:0]     nic_error;
  logic                  steer_mode;
  logic [1:0]            steer_idx;
  logic [N-1:0][CW-1:0]  frame_cnt;
  logic [CW-1:0]         drop_cnt, proto_cnt;

  always #5 clk = ~clk;

  eth_rx_dispatcher #(.NUM_NICS(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rx_data_in        (rx_data),
    .rx_valid_in       (rx_valid),
    .rx_sop_in         (rx_sop),
    .rx_eop_in         (rx_eop),
    .rx_empty_in       (rx_empty),
    .rx_error_in       (rx_error),
    .rx_ready_out      (rx_ready),
    .nic_data_out      (nic_data),
    .nic_valid_out     (nic_valid),
    .nic_sop_out       (nic_sop),
    .nic_eop_out       (nic_eop),
    .nic_empty_out     (nic_empty),
    .nic_error_out     (nic_error),
    .nic_ready_in      (nic_ready),
    .steer_mode_in     (steer_mode),
    .steer_idx_in      (steer_idx),
    .frame_cnt_out     (frame_cnt),
    .drop_cnt_out      (drop_cnt),
    .proto_err_cnt_out (proto_cnt)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[N][$];
  int   rr_m = 0;
  int   frame_m[N] = '{default: 0};
  int   drop_m = 0;
  int   proto_m = 0;
  int   lat_nic = -1;
  int   cur_nic = -1;
  exp_t cur_exp;
  bit   xfer_seen;
  int   cyc, tgt;

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t nic_beat(input int n);
    return '{data: nic_data[n], sop: nic_sop[n], eop: nic_eop[n], empty: nic_empty[n],
             error: nic_error[n]};
  endfunction

  function automatic logic [DW-1:0] mk(input int f, input int b);
    return {8{f[7:0], b[7:0], 16'hA5C3}};
  endfunction

  // One clock: sample/score on the falling edge, return 1 time unit after the rising edge.
  task automatic clk_step();
    exp_t e;
    @(negedge clk);
    for (int n = 0; n < N; n++) begin
      if (lat_nic == n) begin
        chk("latency_valid", 300'(nic_valid[n]), 300'(1));
        if (exp_q[n].size() > 0) chk("latency_beat", 300'(nic_beat(n)), 300'(exp_q[n][$]));
      end
      if (nic_valid[n] && nic_ready[n]) begin
        if (exp_q[n].size() == 0) begin
          chk($sformatf("spurious_nic%0d", n), 300'(nic_valid[n]), 300'(0));
        end else begin
          e = exp_q[n].pop_front();
          chk($sformatf("beat_nic%0d", n), 300'(nic_beat(n)), 300'(e));
        end
      end
    end
    lat_nic = -1;
    if (rx_valid && rx_ready) begin
      xfer_seen = 1'b1;
      if (cur_nic >= 0) begin
        exp_q[cur_nic].push_back(cur_exp);
        lat_nic = cur_nic;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                           input logic [4:0] emp, input logic [5:0] err, input int nic,
                           input logic exp_sop, output int c);
    rx_data  = d;
    rx_sop   = sop;
    rx_eop   = eop;
    rx_empty = emp;
    rx_error = err;
    rx_valid = 1'b1;
    cur_nic  = nic;
    cur_exp  = '{data: d, sop: exp_sop, eop: eop, empty: emp, error: err};
    xfer_seen = 1'b0;
    c = 0;
    while (!xfer_seen && c < 50) begin
      clk_step();
      c++;
    end
    if (!xfer_seen) chk("xfer_timeout", 300'(xfer_seen), 300'(1));
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
    cur_nic  = -1;
  endtask

  task automatic send_frame(input int nb, input int fid, input logic [4:0] last_emp,
                            input logic [5:0] err);
    int t, c;
    if (!steer_mode) t = rr_m;
    else             t = (int'(steer_idx) < N) ? int'(steer_idx) : -1;
    if (t >= 0) rr_m = (rr_m + 1) % N;
    else        drop_m++;
    for (int b = 0; b < nb; b++)
      send_beat(mk(fid, b), b == 0, b == nb - 1, (b == nb - 1) ? last_emp : 5'd0, err, t,
                b == 0, c);
    if (t >= 0) frame_m[t]++;
  endtask

  task automatic check_counters(input string tag);
    for (int n = 0; n < N; n++)
      chk($sformatf("%s_frame_cnt%0d", tag, n), 300'(frame_cnt[n]), 300'(frame_m[n]));
    chk({tag, "_drop_cnt"}, 300'(drop_cnt), 300'(drop_m));
    chk({tag, "_proto_cnt"}, 300'(proto_cnt), 300'(proto_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    rx_data = '0; rx_empty = '0; rx_error = '0;
    nic_ready = '1; steer_mode = 1'b0; steer_idx = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 300'(rx_ready), 300'(0));
    chk("rst_valid", 300'(nic_valid), 300'(0));
    check_counters("rst");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin across all NICs
    send_frame(4, 1, 5'd3, 6'h00);
    send_frame(4, 2, 5'd0, 6'h15);
    send_frame(4, 3, 5'd9, 6'h2a);
    repeat (2) clk_step();
    check_counters("rr");

    // Static steering, then a round-robin frame shows where rr_ptr ended up
    steer_mode = 1'b1; steer_idx = 2'd2;
    send_frame(3, 4, 5'd1, 6'h01);
    send_frame(2, 5, 5'd2, 6'h00);
    steer_mode = 1'b0;
    send_frame(2, 6, 5'd0, 6'h00);
    steer_mode = 1'b1; steer_idx = 2'd3;
    send_frame(3, 7, 5'd0, 6'h00);
    steer_mode = 1'b0;
    repeat (2) clk_step();
    check_counters("static");

    // Backpressure on NIC1 mid-frame
    send_frame(2, 8, 5'd0, 6'h00);
    tgt = rr_m;
    rr_m = (rr_m + 1) % N;
    send_beat(mk(9, 0), 1'b1, 1'b0, 5'd0, 6'h00, tgt, 1'b1, cyc);
    send_beat(mk(9, 1), 1'b0, 1'b0, 5'd0, 6'h00, tgt, 1'b0, cyc);
    nic_ready[tgt] = 1'b0;
    rx_data = mk(9, 2); rx_valid = 1'b1; cur_nic = tgt;
    repeat (3) begin
      clk_step();
      chk("bp_ready", 300'(rx_ready), 300'(0));
      chk("bp_idle_nic0", 300'(nic_valid[0]), 300'(0));
      chk("bp_idle_nic2", 300'(nic_valid[2]), 300'(0));
    end
    nic_ready[tgt] = 1'b1;
    send_beat(mk(9, 2), 1'b0, 1'b0, 5'd0, 6'h00, tgt, 1'b0, cyc);
    send_beat(mk(9, 3), 1'b0, 1'b1, 5'd4, 6'h00, tgt, 1'b0, cyc);
    frame_m[tgt]++;
    repeat (2) clk_step();
    check_counters("bp");

    // Headless beats discarded, then a stray SOP inside a frame
    send_beat(mk(10, 0), 1'b0, 1'b0, 5'd0, 6'h00, -1, 1'b0, cyc);
    send_beat(mk(10, 1), 1'b0, 1'b0, 5'd0, 6'h00, -1, 1'b0, cyc);
    send_beat(mk(10, 2), 1'b0, 1'b1, 5'd0, 6'h00, -1, 1'b0, cyc);
    proto_m++;
    tgt = rr_m;
    rr_m = (rr_m + 1) % N;
    send_beat(mk(11, 0), 1'b1, 1'b0, 5'd0, 6'h00, tgt, 1'b1, cyc);
    send_beat(mk(11, 1), 1'b1, 1'b0, 5'd0, 6'h00, tgt, 1'b0, cyc);
    send_beat(mk(11, 2), 1'b0, 1'b1, 5'd5, 6'h00, tgt, 1'b0, cyc);
    proto_m++;
    frame_m[tgt]++;
    repeat (2) clk_step();
    check_counters("proto");

    // Single-beat frame followed back-to-back by a new SOP
    tgt = rr_m;
    rr_m = (rr_m + 1) % N;
    send_beat(mk(12, 0), 1'b1, 1'b1, 5'd7, 6'h3f, tgt, 1'b1, cyc);
    frame_m[tgt]++;
    tgt = rr_m;
    rr_m = (rr_m + 1) % N;
    send_beat(mk(13, 0), 1'b1, 1'b0, 5'd0, 6'h00, tgt, 1'b1, cyc);
    chk("b2b_sop_cycles", 300'(cyc), 300'(1));
    send_beat(mk(13, 1), 1'b0, 1'b1, 5'd0, 6'h00, tgt, 1'b0, cyc);
    frame_m[tgt]++;
    repeat (2) clk_step();
    check_counters("single");

    // Reset in the middle of a 5-beat frame
    tgt = rr_m;
    send_beat(mk(14, 0), 1'b1, 1'b0, 5'd0, 6'h00, tgt, 1'b1, cyc);
    send_beat(mk(14, 1), 1'b0, 1'b0, 5'd0, 6'h00, tgt, 1'b0, cyc);
    reset_n = 1'b0;
    #1;
    for (int n = 0; n < N; n++) begin
      exp_q[n].delete();
      frame_m[n] = 0;
    end
    rr_m = 0; drop_m = 0; proto_m = 0; lat_nic = -1;
    chk("midrst_valid", 300'(nic_valid), 300'(0));
    chk("midrst_ready", 300'(rx_ready), 300'(0));
    check_counters("midrst");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(3, 15, 5'd2, 6'h00);
    repeat (3) clk_step();
    check_counters("postrst");
    for (int n = 0; n < N; n++)
      chk($sformatf("drained_nic%0d", n), 300'(exp_q[n].size()), 300'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
